// File: rtl/csa_pkg.sv
// Shared constants and state encoding for the carry-save resolver.
package csa_pkg;

    localparam int CSA_IN_W  = 16;
    localparam int CSA_SUM_W = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    // Number of ADD cycles needed to cover the full result width.
    function automatic int csa_nslice(input int slice);
        return (CSA_SUM_W + slice - 1) / slice;
    endfunction

endpackage

// File: rtl/csa_slice_add.sv
// W-bit ripple slice adder with carry-in and carry-out.
module csa_slice_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Plain binary add; all operands extended to W+1 bits so the carry lands in the MSB.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair (s_in + 2*c_in) into an 18-bit binary result,
// SLICE bits per clock, using a single shared slice adder.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] s_in,
    input  logic [15:0] c_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] sum_out,
    output logic        busy
);

    localparam int NSLICE = csa_nslice(SLICE);
    // Operands and result are padded so the top slice is simply zero-extended.
    localparam int PAD_W  = NSLICE * SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    csa_state_e         state;
    logic [PAD_W-1:0]   a_reg;
    logic [PAD_W-1:0]   b_reg;
    logic [PAD_W-1:0]   res_reg;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [SLICE-1:0]       slice_sum;
    logic                   slice_cout;
    logic [PAD_W+SLICE-1:0] res_cat;

    // Operands are shifted down each cycle, so slice k is always in the low bits.
    csa_slice_add #(
        .W (SLICE)
    ) u_slice_add (
        .a    (a_reg[SLICE-1:0]),
        .b    (b_reg[SLICE-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // New slice enters at the top; after NSLICE shifts slice 0 sits at bit 0.
    assign res_cat = {slice_sum, res_reg};

    // Result is only visible while it is valid.
    assign sum_out = out_valid ? res_reg[CSA_SUM_W-1:0] : '0;

    // Control FSM plus operand/result datapath, all outputs registered.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= PAD_W'({2'b00, s_in});
                        b_reg    <= PAD_W'({1'b0, c_in, 1'b0});
                        carry    <= 1'b0;
                        cnt      <= '0;
                        state    <= ADD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ADD: begin
                    a_reg   <= a_reg >> SLICE;
                    b_reg   <= b_reg >> SLICE;
                    res_reg <= res_cat[PAD_W+SLICE-1:SLICE];
                    // Carry out of the final slice is always zero and is never consumed.
                    carry   <= slice_cout;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_SLICE) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: directed vectors on the SLICE=4
// instance plus randomized pairs on SLICE = 4, 1, 7 and 18 instances.
module tb_csa_resolver;
    import csa_pkg::*;

    localparam int NI = 4;
    localparam int SL [NI] = '{4, 1, 7, 18};
    localparam int NRAND = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv   [NI];
    logic        ir   [NI];
    logic        ov   [NI];
    logic        ordy [NI];
    logic        bz   [NI];
    logic [15:0] si   [NI];
    logic [15:0] ci   [NI];
    logic [17:0] so   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            csa_resolver #(
                .SLICE (SL[g])
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (iv[g]),
                .in_ready  (ir[g]),
                .s_in      (si[g]),
                .c_in      (ci[g]),
                .out_valid (ov[g]),
                .out_ready (ordy[g]),
                .sum_out   (so[g]),
                .busy      (bz[g])
            );
        end
    endgenerate

    typedef struct {
        string       name;
        logic [15:0] s;
        logic [15:0] c;
        int          hold;
        logic [17:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction on instance idx: handshake, latency, result,
    // hold under backpressure, then release and confirm return to idle.
    task automatic run_pair(input int idx, input logic [15:0] s, input logic [15:0] c,
                            input int hold, input logic [17:0] exp, input string tag);
        int          exp_lat;
        int          lat;
        int          waitc;
        logic [17:0] first;
        bit          ok_quiet;
        bit          ok_stable;
        exp_lat = (CSA_SUM_W + SL[idx] - 1) / SL[idx] + 1;
        waitc = 0;
        while (!ir[idx] && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, " in_ready_idle"}, 32'(ir[idx]), 32'd1);
        check({tag, " sum_out_idle_zero"}, 32'(so[idx]), 32'd0);
        if (!ir[idx]) return;
        iv[idx] = 1'b1;
        si[idx] = s;
        ci[idx] = c;
        @(posedge clk); #1;
        iv[idx] = 1'b0;
        lat = 1;
        ok_quiet = 1'b1;
        while (!ov[idx] && lat < 200) begin
            if (so[idx] != 18'd0 || ir[idx] || !bz[idx]) ok_quiet = 1'b0;
            si[idx] = 16'($urandom);
            ci[idx] = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " quiet_while_adding"}, 32'(ok_quiet), 32'd1);
        check({tag, " sum_out"}, 32'(so[idx]), 32'(exp));
        first = so[idx];
        ok_stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            si[idx] = 16'($urandom);
            ci[idx] = 16'($urandom);
            @(posedge clk); #1;
            if (so[idx] != first || !ov[idx] || ir[idx] || !bz[idx]) ok_stable = 1'b0;
        end
        if (hold > 0) check({tag, " stable_under_backpressure"}, 32'(ok_stable), 32'd1);
        ordy[idx] = 1'b1;
        check({tag, " in_ready_low_at_accept"}, 32'(ir[idx]), 32'd0);
        @(posedge clk); #1;
        ordy[idx] = 1'b0;
        check({tag, " out_valid_dropped"}, 32'(ov[idx]), 32'd0);
        check({tag, " in_ready_after_accept"}, 32'(ir[idx]), 32'd1);
        check({tag, " sum_out_zero_after"}, 32'(so[idx]), 32'd0);
    endtask

    initial begin
        vec_t        vecs [6];
        logic [15:0] rs;
        logic [15:0] rc;
        logic [17:0] model;

        vecs[0] = '{"zero",      16'h0000, 16'h0000, 0,  18'h00000};
        vecs[1] = '{"all_ones",  16'hFFFF, 16'hFFFF, 0,  18'h2FFFD};
        vecs[2] = '{"slice_cy",  16'h000F, 16'h0001, 0,  18'h00011};
        vecs[3] = '{"hold10",    16'h1234, 16'h0001, 10, 18'h01236};
        vecs[4] = '{"msb_pair",  16'h8000, 16'h8000, 2,  18'h18000};
        vecs[5] = '{"long_cy",   16'h0001, 16'h7FFF, 1,  18'h0FFFF};

        for (int i = 0; i < NI; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
            si[i]   = '0;
            ci[i]   = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_in_ready_s%0d", SL[i]), 32'(ir[i]), 32'd1);
            check($sformatf("reset_out_valid_s%0d", SL[i]), 32'(ov[i]), 32'd0);
            check($sformatf("reset_busy_s%0d", SL[i]), 32'(bz[i]), 32'd0);
            check($sformatf("reset_sum_out_s%0d", SL[i]), 32'(so[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on the SLICE=4 instance.
        for (int i = 0; i < 6; i++) begin
            run_pair(0, vecs[i].s, vecs[i].c, vecs[i].hold, vecs[i].exp, vecs[i].name);
        end

        // Reset asserted during the third ADD cycle aborts the operation.
        check("abort in_ready_idle", 32'(ir[0]), 32'd1);
        iv[0] = 1'b1;
        si[0] = 16'h5555;
        ci[0] = 16'h1111;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort busy_in_add", 32'(bz[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(ov[0]), 32'd0);
        check("abort sum_out", 32'(so[0]), 32'd0);
        check("abort in_ready", 32'(ir[0]), 32'd1);
        check("abort busy", 32'(bz[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort no_result", 32'(ov[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_pair(0, 16'h0002, 16'h0003, 0, 18'h00008, "post_reset");

        // Randomized sweep on every SLICE instance against s + 2*c.
        for (int idx = 0; idx < NI; idx++) begin
            for (int n = 0; n < NRAND; n++) begin
                rs = 16'($urandom);
                rc = 16'($urandom);
                if ($urandom_range(0, 7) == 0) rs = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
                if ($urandom_range(0, 7) == 0) rc = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
                model = 18'(rs) + 18'(2 * int'(rc));
                run_pair(idx, rs, rc, $urandom_range(0, 3), model, $sformatf("rand_s%0d", SL[idx]));
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk); #1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
